// File: rtl/instr_mem_responder_pkg.sv
// Shared types and constants for the instruction-memory responder.
package instr_mem_responder_pkg;

  typedef enum logic [1:0] {
    IMEM_IDLE,
    IMEM_WAIT,
    IMEM_RESP
  } imem_state_e;

  localparam logic [31:0] NOP_INSTR_WORD = 32'h0000_0013;

  // True when a 30-bit word index lies inside a store of 'depth' words.
  function automatic logic idx_in_range(input logic [29:0] idx, input int unsigned depth);
    return ({2'b00, idx} < depth);
  endfunction

endpackage

// File: rtl/instr_mem_responder_if.sv
// Fetch request/grant/valid bus plus the side load port.
// With INSTR_MEM_ERR_EN defined the bus also carries instr_err_op.
interface instr_mem_responder_if;

  logic        mem_en;
  logic        instr_req_ip;
  logic [31:0] instr_addr_ip;
  logic        instr_gnt_op;
  logic        instr_valid_op;
  logic [31:0] instr_data_op;
  logic        busy_op;
  logic        load_we_ip;
  logic [31:0] load_addr_ip;
  logic [31:0] load_data_ip;
`ifdef INSTR_MEM_ERR_EN
  logic        instr_err_op;
`endif

  // Fetch unit / loader side.
  modport master (
    output mem_en, instr_req_ip, instr_addr_ip,
    output load_we_ip, load_addr_ip, load_data_ip,
`ifdef INSTR_MEM_ERR_EN
    input  instr_err_op,
`endif
    input  instr_gnt_op, instr_valid_op, instr_data_op, busy_op
  );

  // Memory responder side.
  modport slave (
    input  mem_en, instr_req_ip, instr_addr_ip,
    input  load_we_ip, load_addr_ip, load_data_ip,
`ifdef INSTR_MEM_ERR_EN
    output instr_err_op,
`endif
    output instr_gnt_op, instr_valid_op, instr_data_op, busy_op
  );

endinterface

// File: rtl/instr_mem_responder_imem_array.sv
// DEPTH_WORDS x 32 backing store: synchronous write port, asynchronous
// read port sampled by the parent at the grant edge. Range checks live
// in the parent.
module instr_mem_responder_imem_array #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = 10
) (
  input  logic          clock,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];

  // Load-port write.
  // NOTE: the store has no reset on purpose; contents survive rst and a
  // reset on a RAM array would also prevent it mapping to memory macros.
  always_ff @(posedge clock) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_mem_responder.sv
// Responder end of the fetch request/grant/valid interface. Grants a
// request combinationally, returns data LATENCY cycles after the grant.
// Optional macro INSTR_MEM_ERR_EN adds instr_err_op for misaligned or
// out-of-range fetches.
module instr_mem_responder
  import instr_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] NOP_INSTR   = NOP_INSTR_WORD
) (
  input  logic                  clock,
  input  logic                  reset,
  instr_mem_responder_if.slave  bus
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned CNT_INIT = (LATENCY > 1) ? LATENCY - 2 : 0;

  imem_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      pend_q, pend_d;
  logic [31:0]      data_q, data_d;
  logic             pend_err_q, pend_err_d;
  logic             err_q, err_d;

  logic [29:0] req_idx, load_idx;
  logic        req_bad;
  logic        load_ok;
  logic        gnt;
  logic [31:0] rd_word, rd_val;
  logic        unused_low_bits;

  assign req_idx  = bus.instr_addr_ip[31:2];
  assign load_idx = bus.load_addr_ip[31:2];
  assign load_ok  = bus.load_we_ip && idx_in_range(load_idx, DEPTH_WORDS);
  assign unused_low_bits = ^{bus.instr_addr_ip[1:0], bus.load_addr_ip[1:0]};

`ifdef INSTR_MEM_ERR_EN
  assign req_bad = !idx_in_range(req_idx, DEPTH_WORDS) || (bus.instr_addr_ip[1:0] != 2'b00);
`else
  assign req_bad = !idx_in_range(req_idx, DEPTH_WORDS);
`endif

  // Grant is gated by reset so nothing is accepted while reset is held.
  assign gnt = reset && bus.mem_en && bus.instr_req_ip &&
               (state_q == IMEM_IDLE || state_q == IMEM_RESP);

  instr_mem_responder_imem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clock   (clock),
    .we_i    (load_ok),
    .waddr_i (load_idx[AW-1:0]),
    .wdata_i (bus.load_data_ip),
    .raddr_i (req_idx[AW-1:0]),
    .rdata_o (rd_word)
  );

  assign rd_val = req_bad ? NOP_INSTR : rd_word;

  // Next-state, counter and data-path decode.
  // NOTE: every output of this block gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    pend_err_d = pend_err_q;
    data_d     = data_q;
    err_d      = 1'b0;
    case (state_q)
      IMEM_IDLE, IMEM_RESP: begin
        if (gnt) begin
          pend_d     = rd_val;
          pend_err_d = req_bad;
          cnt_d      = CNT_W'(CNT_INIT);
          state_d    = (LATENCY == 1) ? IMEM_RESP : IMEM_WAIT;
        end else begin
          state_d = IMEM_IDLE;
        end
      end
      IMEM_WAIT: begin
        if (cnt_q == '0) state_d = IMEM_RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IMEM_IDLE;
    endcase
    // Output data only changes when a response is presented, so it holds
    // its last value once valid drops.
    if (state_d == IMEM_RESP) begin
      data_d = pend_d;
      err_d  = pend_err_d;
    end
  end

  // State and registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IMEM_IDLE;
      cnt_q      <= '0;
      pend_q     <= '0;
      pend_err_q <= 1'b0;
      data_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      pend_err_q <= pend_err_d;
      data_q     <= data_d;
      err_q      <= err_d;
    end
  end

  assign bus.instr_gnt_op   = gnt;
  assign bus.instr_valid_op = (state_q == IMEM_RESP);
  assign bus.instr_data_op  = data_q;
  assign bus.busy_op        = (state_q != IMEM_IDLE);
`ifdef INSTR_MEM_ERR_EN
  assign bus.instr_err_op   = err_q;
`endif

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed-vector bench for instr_mem_responder with a response scoreboard.
module tb_instr_mem_responder;

  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef INSTR_MEM_ERR_EN
  localparam logic ERR_BUILD = 1'b1;
`else
  localparam logic ERR_BUILD = 1'b0;
`endif

  typedef struct {
    logic        mem_en;
    logic        req;
    logic [31:0] addr;
    logic        ld_we;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic        exp_gnt;
    logic        exp_valid;
    logic        exp_busy;
    logic        push;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } resp_t;

  logic clock;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  resp_t exp_q[$];
  logic [31:0] last_data = '0;

  instr_mem_responder_if bus ();

  instr_mem_responder dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t v(input logic en, input logic req, input logic [31:0] addr,
                             input logic we, input logic [31:0] la, input logic [31:0] ld,
                             input logic eg, input logic ev, input logic eb,
                             input logic push, input logic [31:0] ed, input logic ee);
    vec_t x;
    x.mem_en = en; x.req = req; x.addr = addr;
    x.ld_we = we; x.ld_addr = la; x.ld_data = ld;
    x.exp_gnt = eg; x.exp_valid = ev; x.exp_busy = eb;
    x.push = push; x.exp_data = ed; x.exp_err = ee;
    return x;
  endfunction

  // One cycle: drive at cycle start, check mid-cycle, advance past the edge.
  task automatic run_vec(input vec_t x, input string tag);
    bus.mem_en        = x.mem_en;
    bus.instr_req_ip  = x.req;
    bus.instr_addr_ip = x.addr;
    bus.load_we_ip    = x.ld_we;
    bus.load_addr_ip  = x.ld_addr;
    bus.load_data_ip  = x.ld_data;
    if (x.push) exp_q.push_back('{data: x.exp_data, err: x.exp_err});
    @(negedge clock);
    check({tag, "_gnt"},   32'(bus.instr_gnt_op),   32'(x.exp_gnt));
    check({tag, "_valid"}, 32'(bus.instr_valid_op), 32'(x.exp_valid));
    check({tag, "_busy"},  32'(bus.busy_op),        32'(x.exp_busy));
    @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d, input string tag);
    run_vec(v(1, 0, 0, 1, a, d, 0, 0, 0, 0, 0, 0), tag);
  endtask

  task automatic idle(input logic ev, input logic eb, input string tag);
    run_vec(v(1, 0, 0, 0, 0, 0, 0, ev, eb, 0, 0, 0), tag);
  endtask

  // Single read with LATENCY=2: grant, wait, valid, back to idle.
  task automatic read1(input logic [31:0] a, input logic [31:0] ed, input logic ee, input string tag);
    run_vec(v(1, 1, a, 0, 0, 0, 1, 0, 0, 1, ed, ee), {tag, "_c0"});
    idle(0, 1, {tag, "_c1"});
    idle(1, 1, {tag, "_c2"});
    idle(0, 0, {tag, "_c3"});
  endtask

  // Scoreboard monitor: pops on every valid, checks hold otherwise.
  always @(negedge clock) begin
    if (!reset) begin
      last_data = '0;
    end else if (bus.instr_valid_op) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'(bus.instr_valid_op), 32'd0);
      end else begin
        resp_t e;
        e = exp_q.pop_front();
        check("resp_data", bus.instr_data_op, e.data);
`ifdef INSTR_MEM_ERR_EN
        check("resp_err", 32'(bus.instr_err_op), 32'(e.err));
`endif
        last_data = e.data;
      end
    end else begin
      check("data_hold", bus.instr_data_op, last_data);
`ifdef INSTR_MEM_ERR_EN
      check("err_idle", 32'(bus.instr_err_op), 32'd0);
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset             = 1'b0;
    bus.mem_en        = 1'b1;
    bus.instr_req_ip  = 1'b1;
    bus.instr_addr_ip = 32'h4;
    bus.load_we_ip    = 1'b0;
    bus.load_addr_ip  = '0;
    bus.load_data_ip  = '0;

    // Reset state, with a live request that must not be granted.
    #12;
    check("rst_gnt",   32'(bus.instr_gnt_op),   32'd0);
    check("rst_valid", 32'(bus.instr_valid_op), 32'd0);
    check("rst_data",  bus.instr_data_op,       32'd0);
    check("rst_busy",  32'(bus.busy_op),        32'd0);
    bus.instr_req_ip = 1'b0;
    #10 reset = 1'b1;
    @(posedge clock);
    #1;

    // Basic single read.
    load(32'h4, 32'h0050_0093, "t1_ld");
    read1(32'h4, 32'h0050_0093, 1'b0, "t1");

    // Back-to-back requests with req held high.
    load(32'h0, 32'h0000_000A, "t2_ld0");
    load(32'h4, 32'h0000_000B, "t2_ld1");
    run_vec(v(1, 1, 32'h0, 0, 0, 0, 1, 0, 0, 1, 32'hA, 0), "t2_c0");
    run_vec(v(1, 1, 32'h4, 0, 0, 0, 0, 0, 1, 0, 0, 0),     "t2_c1");
    run_vec(v(1, 1, 32'h4, 0, 0, 0, 1, 1, 1, 1, 32'hB, 0), "t2_c2");
    idle(0, 1, "t2_c3");
    idle(1, 1, "t2_c4");
    idle(0, 0, "t2_c5");

    // mem_en blocks grants until it rises.
    run_vec(v(0, 1, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0),     "t3_c0");
    run_vec(v(0, 1, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0),     "t3_c1");
    run_vec(v(0, 1, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0),     "t3_c2");
    run_vec(v(1, 1, 32'h0, 0, 0, 0, 1, 0, 0, 1, 32'hA, 0), "t3_c3");
    idle(0, 1, "t3_c4");
    idle(1, 1, "t3_c5");
    idle(0, 0, "t3_c6");

    // Range boundary, discarded out-of-range load, misaligned address.
    load(32'h0000_0FFC, 32'h1234_5678, "t4_ld_last");
    load(32'h0000_1000, 32'hDEAD_BEEF, "t4_ld_oor");
    read1(32'h0000_1000, NOP, ERR_BUILD, "t4_oor");
    read1(32'h0000_0FFC, 32'h1234_5678, 1'b0, "t4_last");
    read1(32'h0000_0000, 32'hA, 1'b0, "t4_w0");
    read1(32'h0000_0006, ERR_BUILD ? NOP : 32'hB, ERR_BUILD, "t4_mis");

    // Reset during IMEM_WAIT drops the request.
    run_vec(v(1, 1, 32'h4, 0, 0, 0, 1, 0, 0, 0, 0, 0), "t5_c0");
    bus.instr_req_ip = 1'b0;
    check("t5_busy_pre", 32'(bus.busy_op), 32'd1);
    #2 reset = 1'b0;
    bus.instr_req_ip = 1'b1;
    #1;
    check("t5_rst_gnt",   32'(bus.instr_gnt_op),   32'd0);
    check("t5_rst_valid", 32'(bus.instr_valid_op), 32'd0);
    check("t5_rst_data",  bus.instr_data_op,       32'd0);
    check("t5_rst_busy",  32'(bus.busy_op),        32'd0);
    bus.instr_req_ip = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    #2 reset = 1'b1;
    @(posedge clock);
    #1;
    idle(0, 0, "t5_post0");
    idle(0, 0, "t5_post1");
    idle(0, 0, "t5_post2");
    read1(32'h4, 32'hB, 1'b0, "t5_reread");

    // Load and grant to the same word in one cycle: read sees old value.
    load(32'h8, 32'h0000_0007, "t6_ld");
    run_vec(v(1, 1, 32'h8, 1, 32'h8, 32'hC, 1, 0, 0, 1, 32'h7, 0), "t6_c0");
    idle(0, 1, "t6_c1");
    idle(1, 1, "t6_c2");
    idle(0, 0, "t6_c3");
    read1(32'h8, 32'hC, 1'b0, "t6_new");

    idle(0, 0, "drain");
    check("queue_drain", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
